// File: rtl/detect_round_ctrl.sv
// Round controller for a three-way first-to-respond detector: arms on start,
// rejects false starts, latches the first riser (a>b>c), holds it, or times out.
module detect_round_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLD_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [2:0] y,
    output logic       busy,
    output logic       tie,
    output logic       timeout,
    output logic       done,
    output logic [3:0] wins_a,
    output logic [3:0] wins_b,
    output logic [3:0] wins_c
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  HLAST = 8'(HOLD_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] tcnt;
    logic [7:0]  hcnt;

    logic       any_in;
    logic       multi_in;
    logic [2:0] winner;

    assign any_in   = a | b | c;
    assign multi_in = (a & b) | (a & c) | (b & c);
    assign winner   = a ? 3'b001 : (b ? 3'b010 : 3'b100);
    assign busy     = (state != S_IDLE);

    // Win counters stick at 15 so a long session never wraps back to a small score.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            y       <= 3'b000;
            tie     <= 1'b0;
            timeout <= 1'b0;
            done    <= 1'b0;
            wins_a  <= 4'd0;
            wins_b  <= 4'd0;
            wins_c  <= 4'd0;
            tcnt    <= 16'd0;
            hcnt    <= 8'd0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                y     <= 3'b000;
                tie   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_ARM;
                            y       <= 3'b000;
                            tie     <= 1'b0;
                            timeout <= 1'b0;
                            tcnt    <= 16'd0;
                        end
                    end
                    S_ARM: begin
                        // Any input still high is a false start; wait for a clean all-low cycle.
                        if (!any_in) begin
                            state <= S_WAIT;
                            tcnt  <= 16'd0;
                        end
                    end
                    S_WAIT: begin
                        if (any_in) begin
                            state <= S_HOLD;
                            hcnt  <= 8'd0;
                            y     <= winner;
                            tie   <= multi_in;
                            if (a)      wins_a <= sat_inc(wins_a);
                            else if (b) wins_b <= sat_inc(wins_b);
                            else        wins_c <= sat_inc(wins_c);
                        end else if (tcnt == TLAST) begin
                            state   <= S_IDLE;
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            y       <= 3'b000;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                    S_HOLD: begin
                        if (hcnt == HLAST) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            hcnt <= hcnt + 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_detect_round_ctrl.sv
// Self-checking bench for detect_round_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a round model.
module tb_detect_round_ctrl;

    localparam int TMO  = 8;
    localparam int HOLD = 5;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       a;
    logic       b;
    logic       c;
    logic [2:0] y;
    logic       busy;
    logic       tie;
    logic       timeout;
    logic       done;
    logic [3:0] wins_a;
    logic [3:0] wins_b;
    logic [3:0] wins_c;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 0;

    detect_round_ctrl #(.TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a(a), .b(b), .c(c),
        .y(y), .busy(busy), .tie(tie), .timeout(timeout), .done(done),
        .wins_a(wins_a), .wins_b(wins_b), .wins_c(wins_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Round model: phase of the round plus elapsed/remaining cycle counts.
    typedef enum int {P_IDLE, P_ARMED, P_LISTEN, P_SHOW} phase_t;
    phase_t     mPhase = P_IDLE;
    logic [2:0] mY = 3'b000;
    logic       mTie = 1'b0;
    logic       mTimeout = 1'b0;
    logic       mDone = 1'b0;
    logic [3:0] mWins [3];
    int         waitElapsed = 0;
    int         holdLeft = 0;

    always @(posedge clk) begin
        int n;
        int idx;
        n = int'(a) + int'(b) + int'(c);
        mDone = 1'b0;
        if (!rst) begin
            mPhase = P_IDLE; mY = 3'b000; mTie = 1'b0; mTimeout = 1'b0;
            for (int k = 0; k < 3; k++) mWins[k] = 4'd0;
            waitElapsed = 0; holdLeft = 0;
        end else if (abort) begin
            mPhase = P_IDLE; mY = 3'b000; mTie = 1'b0;
        end else begin
            case (mPhase)
                P_IDLE: if (start) begin
                    mPhase = P_ARMED; mY = 3'b000; mTie = 1'b0; mTimeout = 1'b0;
                end
                P_ARMED: if (n == 0) begin
                    mPhase = P_LISTEN; waitElapsed = 0;
                end
                P_LISTEN: begin
                    if (n > 0) begin
                        idx = a ? 0 : (b ? 1 : 2);
                        mY = 3'(1 << idx);
                        mTie = (n >= 2);
                        if (mWins[idx] < 4'd15) mWins[idx] = mWins[idx] + 4'd1;
                        mPhase = P_SHOW; holdLeft = HOLD;
                    end else begin
                        waitElapsed++;
                        if (waitElapsed == TMO) begin
                            mTimeout = 1'b1; mDone = 1'b1; mY = 3'b000; mPhase = P_IDLE;
                        end
                    end
                end
                P_SHOW: begin
                    holdLeft--;
                    if (holdLeft == 0) begin
                        mDone = 1'b1; mPhase = P_IDLE;
                    end
                end
                default: mPhase = P_IDLE;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model.y",       16'(y),       16'(mY));
            checkOutput("model.tie",     16'(tie),     16'(mTie));
            checkOutput("model.timeout", 16'(timeout), 16'(mTimeout));
            checkOutput("model.done",    16'(done),    16'(mDone));
            checkOutput("model.busy",    16'(busy),    16'(mPhase != P_IDLE));
            checkOutput("model.wins_a",  16'(wins_a),  16'(mWins[0]));
            checkOutput("model.wins_b",  16'(wins_b),  16'(mWins[1]));
            checkOutput("model.wins_c",  16'(wins_c),  16'(mWins[2]));
        end
    end

    // Drive one cycle of inputs, then return just after the edge that samples them.
    task automatic applyStimulus(input logic r, input logic s, input logic ab,
                                 input logic ia, input logic ib, input logic ic);
        @(negedge clk);
        rst = r; start = s; abort = ab; a = ia; b = ib; c = ic;
        @(posedge clk);
        #1;
    endtask

    task automatic idleSteps(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic r, s, ab, ia, ib, ic;
        int   pIn;
        rst = 0; start = 0; abort = 0; a = 0; b = 0; c = 0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkEn = 1;
        checkOutput("reset.y",    16'(y),      16'h0);
        checkOutput("reset.busy", 16'(busy),   16'h0);
        checkOutput("reset.wins", 16'({wins_a, wins_b, wins_c}), 16'h0);

        // b wins on the 5th listening cycle
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idleSteps(4);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("b_win.y",      16'(y),      16'h2);
        checkOutput("b_win.tie",    16'(tie),    16'h0);
        checkOutput("b_win.wins_b", 16'(wins_b), 16'h1);
        idleSteps(HOLD - 1);
        checkOutput("b_win.busy_hold", 16'(busy), 16'h1);
        idleSteps(1);
        checkOutput("b_win.done", 16'(done), 16'h1);
        checkOutput("b_win.busy_end", 16'(busy), 16'h0);
        idleSteps(1);
        checkOutput("b_win.y_persist", 16'(y), 16'h2);

        // a and c together: a wins with tie
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 1);
        checkOutput("tie.y",      16'(y),      16'h1);
        checkOutput("tie.tie",    16'(tie),    16'h1);
        checkOutput("tie.wins_a", 16'(wins_a), 16'h1);
        checkOutput("tie.wins_c", 16'(wins_c), 16'h0);
        idleSteps(HOLD + 1);

        // false start: a held through arming, then c wins
        applyStimulus(1, 1, 0, 1, 0, 0);
        for (int k = 0; k < 20; k++) applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("false_start.busy", 16'(busy), 16'h1);
        checkOutput("false_start.y",    16'(y),    16'h0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("false_start.c_win", 16'(y), 16'h4);
        idleSteps(HOLD + 1);

        // timeout after TMO silent cycles; a fresh start clears it
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idleSteps(TMO - 1);
        checkOutput("tmo.not_yet", 16'(timeout), 16'h0);
        idleSteps(1);
        checkOutput("tmo.flag", 16'(timeout), 16'h1);
        checkOutput("tmo.done", 16'(done),    16'h1);
        checkOutput("tmo.y",    16'(y),       16'h0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("tmo.cleared", 16'(timeout), 16'h0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("abort_arm.busy", 16'(busy), 16'h0);

        // input on the last listening cycle wins instead of timing out
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idleSteps(TMO - 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("edge_win.y",       16'(y),       16'h4);
        checkOutput("edge_win.timeout", 16'(timeout), 16'h0);
        idleSteps(HOLD + 1);

        // sixteen more a wins saturate the counter
        for (int rnd = 0; rnd < 16; rnd++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0, 0);
            applyStimulus(1, 0, 0, 1, 0, 0);
            idleSteps(HOLD + 1);
        end
        checkOutput("sat.wins_a", 16'(wins_a), 16'hF);

        // abort during hold
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("abort.busy",   16'(busy),   16'h0);
        checkOutput("abort.y",      16'(y),      16'h0);
        checkOutput("abort.done",   16'(done),   16'h0);
        checkOutput("abort.wins_a", 16'(wins_a), 16'hF);

        // reset mid-round dominates start and abort
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("rst_mid.busy", 16'(busy), 16'h0);
        checkOutput("rst_mid.wins", 16'({wins_a, wins_b, wins_c}), 16'h0);
        checkOutput("rst_mid.done", 16'(done), 16'h0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("rst_after.y",      16'(y),      16'h2);
        checkOutput("rst_after.wins_b", 16'(wins_b), 16'h1);
        idleSteps(HOLD + 1);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            pIn = (i < 2000) ? 6 : 20;
            r  = ($urandom_range(0, 299) != 0);
            s  = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 49) == 0);
            ia = ($urandom_range(0, pIn - 1) == 0);
            ib = ($urandom_range(0, pIn - 1) == 0);
            ic = ($urandom_range(0, pIn - 1) == 0);
            applyStimulus(r, s, ab, ia, ib, ic);
        end

        @(negedge clk);
        checkEn = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/detect_round_ctrl.md
DETECT_ROUND_CTRL -- requirements
Module: detect_round_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, SHALL set the number of WAIT cycles without any input before the round times out (legal range 1..65535).
REQ-002 Parameter HOLD_CYCLES, default 16, SHALL set the number of cycles the winner is held in HOLD (legal range 1..255).
REQ-003 clk  in  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 start  in  1  SHALL request a new detection round; it is honoured only in IDLE.
REQ-006 abort  in  1  SHALL force a return to IDLE from any state.
REQ-007 a, b, c  in  1 each  SHALL be the contestant signals, already synchronous to clk.
REQ-008 y  out  3  SHALL be the registered one-hot winner: bit0=a, bit1=b, bit2=c, 000=none.
REQ-009 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-010 tie  out  1  SHALL flag that more than one input rose in the winning cycle.
REQ-011 timeout  out  1  SHALL be a sticky flag indicating that the last round expired without a winner.
REQ-012 done  out  1  SHALL be a one-cycle pulse at round completion (winner or timeout).
REQ-013 wins_a, wins_b, wins_c  out  4 each  SHALL be per-input win counters.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ARM, WAIT, HOLD.
REQ-015 IDLE with start=1 SHALL transition to ARM on the next edge, clear y, tie and timeout, and load the timeout counter with 0.
REQ-016 In ARM, while any of a/b/c=1 (false start), the FSM SHALL remain in ARM; once a=b=c=0 in a sampled cycle, it SHALL go to WAIT next cycle.
REQ-017 In WAIT, the timeout counter SHALL increment each cycle in which a=b=c=0.
REQ-018 WAIT, on the first cycle N with any input=1, SHALL in cycle N+1 register y with the winner (priority a>b>c), set tie=1 if two or more inputs were 1 in cycle N, increment that winner's counter, and enter HOLD.
REQ-019 WAIT, when the counter reaches TIMEOUT_CYCLES-1 with no input, SHALL on the next edge set timeout=1, keep y=000, pulse done, and return to IDLE.
REQ-020 An input arriving in the same cycle as counter = TIMEOUT_CYCLES-1 SHALL count as a winner, not a timeout.
REQ-021 HOLD SHALL last exactly HOLD_CYCLES cycles, ignoring a/b/c and start.
REQ-022 On leaving HOLD, the FSM SHALL pulse done for one cycle and return to IDLE.
REQ-023 y and tie SHALL persist in IDLE until the next accepted start.
REQ-024 Win counters SHALL saturate at 15 and never wrap.
REQ-025 Win counters SHALL be cleared only by reset.
REQ-026 abort=1 in any state SHALL cause IDLE next cycle with y=000 and tie=0.
REQ-027 abort SHALL leave timeout and the counters unchanged and SHALL produce no done pulse.
REQ-028 abort SHALL take precedence over a simultaneous winner, timeout or start.
REQ-029 start asserted while busy=1 SHALL be ignored and not queued.
REQ-030 Inputs held high continuously from a previous round SHALL keep the FSM in ARM indefinitely; no winner SHALL be declared.

Reset
REQ-031 rst=0 sampled on a rising edge SHALL force, on that edge: state=IDLE, y=000, busy=0, tie=0, timeout=0, done=0, wins_*=0, timeout and hold counters=0.
REQ-032 Reset asserted mid-round, in any state, SHALL abandon the round with no done pulse.
REQ-033 Reset SHALL dominate abort and start.

Verification
REQ-034 Start, all inputs low, b=1 on the 5th WAIT cycle -> y=010 one cycle later, tie=0, wins_b=1, busy high for HOLD_CYCLES, then done pulse and busy=0.
REQ-035 a and c rise in the same WAIT cycle -> y=001, tie=1, wins_a incremented, wins_c unchanged.
REQ-036 Start with a held high for 20 cycles, then released -> FSM in ARM for those cycles with y=000; WAIT entered 1 cycle after release; later c=1 -> y=100.
REQ-037 TIMEOUT_CYCLES=8 with no input -> after 8 WAIT cycles timeout=1, y=000, done pulse, IDLE; a second start clears timeout.
REQ-038 Sixteen rounds won by a -> wins_a stays at 15; abort during HOLD -> IDLE next cycle, y=000, no done.
REQ-039 rst=0 asserted during WAIT -> all outputs at reset values on the next edge; start after reset release runs a normal round.
